regfile_wport_arbiter: RTL

//  Shares the single register-file write port between two writeback sources:

---
 rtl/regfile_wport_arbiter_pkg.sv | 26 ++
 rtl/regfile_wport_fifo.sv | 63 ++++++
 rtl/regfile_wport_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared widths, register-file constants, arbiter state encodings and the
// write-request record used by the writeback port arbiter.
package regfile_wport_arbiter_pkg;

    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG     = '0;
    localparam logic                   WRITE_ENABLE = 1'b1;

    typedef enum logic {
        ARB_PRIO0  = 1'b0,
        ARB_FORCE1 = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [RADDR_WIDTH-1:0] addr;
        logic [RDATA_WIDTH-1:0] data;
    } wr_req_t;

    // Writes to the hardwired zero register are consumed but never enabled.
    function automatic logic is_real_write(input logic [RADDR_WIDTH-1:0] addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_wport_fifo.sv
// Small synchronous FIFO buffering port-1 writebacks; wrap-bit pointers
// distinguish full from empty without a separate occupancy counter.
module regfile_wport_fifo
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  wr_req_t push_data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output wr_req_t head_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    wr_req_t       mem_q [DEPTH];
    wr_req_t       mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[IW-1:0]] = push_data_i;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single register-file write port between the WB stage (port 0)
// and buffered multi-cycle results (port 1), with a registered output.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid0_i,
    output logic                   ready0_o,
    input  logic [RADDR_WIDTH-1:0] waddr0_i,
    input  logic [RDATA_WIDTH-1:0] wdata0_i,
    input  logic                   valid1_i,
    output logic                   ready1_o,
    input  logic [RADDR_WIDTH-1:0] waddr1_i,
    input  logic [RDATA_WIDTH-1:0] wdata1_i,
    output logic                   we_o,
    output logic [RADDR_WIDTH-1:0] waddr_o,
    output logic [RDATA_WIDTH-1:0] wdata_o,
    output logic                   pend1_o,
    output arb_state_e             state_o
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and a requester keeps its
    // address/data stable while valid & !ready.

    localparam int               CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]    LIMIT = CW'(STARVE_LIMIT);

    arb_state_e             state_q, state_d;
    logic [CW-1:0]          starve_q, starve_d;
    logic                   we_q, we_d;
    logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [RDATA_WIDTH-1:0] wdata_q, wdata_d;

    logic    grant0;
    logic    grant1;
    logic    fifo_full;
    logic    fifo_empty;
    wr_req_t fifo_head;
    wr_req_t fifo_in;

    assign fifo_in = '{addr: waddr1_i, data: wdata1_i};

    regfile_wport_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (valid1_i),
        .push_data_i (fifo_in),
        .pop_i       (grant1),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign ready1_o = !fifo_full;
    assign pend1_o  = !fifo_empty;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ready0_o = 1'b1;
        grant0   = 1'b0;
        grant1   = 1'b0;
        unique case (state_q)
            ARB_PRIO0: begin
                ready0_o = 1'b1;
                if (valid0_i) begin
                    grant0 = 1'b1;
                end else if (!fifo_empty) begin
                    grant1 = 1'b1;
                end
                // Count only port-0 wins over a waiting FIFO entry.
                if (fifo_empty || grant1) begin
                    starve_d = '0;
                end else if (grant0) begin
                    if (starve_q == LIMIT - CW'(1)) begin
                        state_d  = ARB_FORCE1;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + CW'(1);
                    end
                end
            end
            ARB_FORCE1: begin
                ready0_o = 1'b0;
                grant1   = !fifo_empty;
                starve_d = '0;
                state_d  = ARB_PRIO0;
            end
            default: begin
                state_d = ARB_PRIO0;
            end
        endcase
    end

    always_comb begin
        we_d    = !WRITE_ENABLE;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant0) begin
            we_d    = is_real_write(waddr0_i) ? WRITE_ENABLE : !WRITE_ENABLE;
            waddr_d = waddr0_i;
            wdata_d = wdata0_i;
        end else if (grant1) begin
            we_d    = is_real_write(fifo_head.addr) ? WRITE_ENABLE : !WRITE_ENABLE;
            waddr_d = fifo_head.addr;
            wdata_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_PRIO0;
            starve_q <= '0;
            we_q     <= !WRITE_ENABLE;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign state_o = state_q;

endmodule
